// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and compile-time sizing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Clock cycles per oversample tick (integer division)
    function automatic int unsigned div_calc(input int unsigned clk_hz, input int unsigned baud,
                                             input int unsigned oversample);
        return clk_hz / (baud * oversample);
    endfunction

    // Bits needed to hold 0..max_value, never less than 1
    function automatic int unsigned width_for(input int unsigned max_value);
        return (max_value < 2) ? 1 : clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with occupancy count. A push into a full FIFO is ignored;
// callers that care about lost data test 'full' themselves.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Storage needs no reset: only entries below 'level' are ever read out
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_pacer.sv
// 8N1 oversampling receiver feeding a byte FIFO, with a paced release stage that
// spaces rxReady pulses at least GAP_CYCLES apart for the downstream command processor.
module uart_rx_pacer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rxd,
    output logic                       rxReady,
    output logic [7:0]                 rxData,
    output logic                       frame_err,
    output logic                       overrun,
    output logic [clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned DIV   = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = width_for(DIV - 1);
    localparam int unsigned CNT_W = width_for(OVERSAMPLE - 1);
    localparam int unsigned GAP_W = width_for(GAP_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             rxd_s;
    rx_state_e        state_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             at_mid;
    logic [2:0]       bit_q;
    logic [1:0]       samp_q;
    logic             maj;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             pop;
    logic [GAP_W-1:0] gap_q;

    // Two-flop synchroniser on the raw line, reset to the idle-high level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxd_s = sync_q[1];

    // Oversample tick divider: parked at 0 in IDLE, so every frame starts from a fresh phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (state_q == IDLE || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (state_q != IDLE) && (div_q == DIV_W'(DIV - 1));

    // The sample counter free-wraps across bits. Decisions are taken on the tick after the
    // nominal centre, when the third of the three centred samples arrives; that lands on the
    // same counter value in every bit because the counter wraps once per bit period.
    assign cnt_next = (cnt_q == CNT_W'(OVERSAMPLE - 1)) ? '0 : cnt_q + 1'b1;
    assign at_mid   = (cnt_q == CNT_W'(OVERSAMPLE / 2));
    assign maj      = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxd_s) | (samp_q[0] & rxd_s);

    // Deframer FSM: start validation, LSB-first shifting, stop check, registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            samp_q       <= 2'b11;
            shift_q      <= '0;
            frame_err    <= 1'b0;
            byte_valid_q <= 1'b0;
        end else begin
            frame_err    <= 1'b0;
            byte_valid_q <= 1'b0;
            if (tick) samp_q <= {samp_q[0], rxd_s};
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt_q <= cnt_next;
                        if (at_mid) begin
                            if (maj) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= DATA;
                                bit_q   <= '0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_q <= cnt_next;
                        if (at_mid) begin
                            shift_q <= {maj, shift_q[7:1]};
                            if (bit_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt_q <= cnt_next;
                        if (at_mid) begin
                            // Leave without waiting out the stop bit so the next start edge is seen
                            state_q <= IDLE;
                            if (maj) begin
                                byte_valid_q <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (byte_valid_q),
        .push_data (shift_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign pop = !fifo_empty && (gap_q == '0);

    // Release pacer: one byte per gap window; also flags a completed byte that found the FIFO full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxReady <= 1'b0;
            rxData  <= '0;
            gap_q   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= byte_valid_q && fifo_full;
            if (pop) begin
                rxReady <= 1'b1;
                rxData  <= fifo_head;
                gap_q   <= GAP_W'(GAP_CYCLES - 1);
            end else begin
                rxReady <= 1'b0;
                if (gap_q != '0) gap_q <= gap_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_pacer.sv
// Directed bench for uart_rx_pacer. Three receivers share the serial stimulus:
// dut (default gap), mid (gap 6000, builds a backlog to expose pacing and FIFO order)
// and big (gap 1e6, fills up to exercise overrun and reset with queued bytes).
module tb_uart_rx_pacer;

    localparam int unsigned CLK_HZ   = 50_000_000;
    localparam int unsigned BAUD     = 115200;
    localparam int          BIT_CLKS = (CLK_HZ / (BAUD * 16)) * 16;  // 27 * 16 = 432
    localparam int          MID_GAP  = 6000;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic reset_big = 1'b1;
    logic rxd       = 1'b1;
    logic rxd_big   = 1'b1;

    logic       rx_ready, frame_err, overrun;
    logic [7:0] rx_data;
    logic [3:0] fifo_level;
    logic       mid_ready, mid_fe, mid_ovr;
    logic [7:0] mid_data;
    logic [3:0] mid_level;
    logic       big_ready, big_fe, big_ovr;
    logic [7:0] big_data;
    logic [3:0] big_level;

    always #5 clk = ~clk;

    uart_rx_pacer u_dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rxReady    (rx_ready),
        .rxData     (rx_data),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    uart_rx_pacer #(.GAP_CYCLES(MID_GAP)) u_mid (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rxReady    (mid_ready),
        .rxData     (mid_data),
        .frame_err  (mid_fe),
        .overrun    (mid_ovr),
        .fifo_level (mid_level)
    );

    uart_rx_pacer #(.GAP_CYCLES(1_000_000)) u_big (
        .clk        (clk),
        .reset      (reset_big),
        .rxd        (rxd_big),
        .rxReady    (big_ready),
        .rxData     (big_data),
        .frame_err  (big_fe),
        .overrun    (big_ovr),
        .fifo_level (big_level)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] dut_q[$];
    int         dut_t[$];
    int         dut_fe_n = 0, dut_ov_n = 0;
    logic [7:0] mid_q[$];
    int         mid_t[$];
    int         mid_fe_n = 0, mid_ov_n = 0;
    logic [7:0] big_q[$];
    int         big_fe_n = 0, big_ov_n = 0;

    // Pulse recorder, sampled away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (rx_ready === 1'b1) begin dut_q.push_back(rx_data); dut_t.push_back(cyc); end
        if (mid_ready === 1'b1) begin mid_q.push_back(mid_data); mid_t.push_back(cyc); end
        if (big_ready === 1'b1) big_q.push_back(big_data);
        if (frame_err === 1'b1) dut_fe_n++;
        if (overrun === 1'b1) dut_ov_n++;
        if (mid_fe === 1'b1) mid_fe_n++;
        if (mid_ovr === 1'b1) mid_ov_n++;
        if (big_fe === 1'b1) big_fe_n++;
        if (big_ovr === 1'b1) big_ov_n++;
    end

    task automatic drive_line(input bit big_only, input logic v);
        if (!big_only) rxd = v;
        rxd_big = v;
    endtask

    task automatic send_frame(input bit big_only, input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive_line(big_only, bits[i]);
            repeat (BIT_CLKS) @(negedge clk);
        end
        drive_line(big_only, 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rxReady got %b want 0", rx_ready); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rxData got %h want 00", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (big_level !== 4'd0) begin errors++; $display("FAIL reset_big_level got %0d want 0", big_level); end
        reset     = 1'b0;
        reset_big = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int n0, fe0, ov0;
        logic [7:0] got;
        n0 = dut_q.size(); fe0 = dut_fe_n; ov0 = dut_ov_n;
        send_frame(1'b0, 8'hA5, 1'b1);
        repeat (40) @(negedge clk);
        got = (dut_q.size() > n0) ? dut_q[n0] : 8'hxx;
        checks++; if (dut_q.size() - n0 != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", dut_q.size() - n0); end
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", got); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", rx_data); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level got %0d want 0", fifo_level); end
        checks++; if (dut_fe_n != fe0) begin errors++; $display("FAIL single_fe got %0d want 0", dut_fe_n - fe0); end
        checks++; if (dut_ov_n != ov0) begin errors++; $display("FAIL single_ov got %0d want 0", dut_ov_n - ov0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [5];
        logic [7:0] got;
        logic [7:0] cmd;
        logic [31:0] seed;
        int n0, min_sp;
        msg = '{8'h06, 8'h01, 8'h02, 8'h03, 8'h04};
        n0 = dut_q.size();
        for (int i = 0; i < 5; i++) send_frame(1'b0, msg[i], 1'b1);
        repeat (40) @(negedge clk);
        checks++; if (dut_q.size() - n0 != 5) begin errors++; $display("FAIL b2b_pulses got %0d want 5", dut_q.size() - n0); end
        cmd = 8'h00; seed = 32'h0; min_sp = 1 << 30;
        for (int i = 0; i < 5; i++) begin
            got = (dut_q.size() > n0 + i) ? dut_q[n0 + i] : 8'hxx;
            checks++; if (got !== msg[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, got, msg[i]); end
            if (i == 0) cmd = got;
            else seed[8*(i-1) +: 8] = got;
            if (i > 0 && dut_t.size() > n0 + i) begin
                if (dut_t[n0 + i] - dut_t[n0 + i - 1] < min_sp) min_sp = dut_t[n0 + i] - dut_t[n0 + i - 1];
            end
        end
        // Processor model: command byte followed by a 32-bit seed, little-endian
        checks++; if (cmd !== 8'h06) begin errors++; $display("FAIL b2b_cmd got %h want 06", cmd); end
        checks++; if (seed !== 32'h04030201) begin errors++; $display("FAIL b2b_seed got %h want 04030201", seed); end
        checks++; if (min_sp < 4) begin errors++; $display("FAIL b2b_spacing got %0d want >=4", min_sp); end
    endtask

    task automatic test_frame_err();
        int n0, fe0;
        logic [7:0] got;
        n0 = dut_q.size(); fe0 = dut_fe_n;
        send_frame(1'b0, 8'h55, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        checks++; if (dut_q.size() != n0) begin errors++; $display("FAIL ferr_no_ready got %0d want 0", dut_q.size() - n0); end
        send_frame(1'b0, 8'h0F, 1'b1);
        repeat (40) @(negedge clk);
        got = (dut_q.size() > n0) ? dut_q[n0] : 8'hxx;
        checks++; if (dut_fe_n - fe0 != 1) begin errors++; $display("FAIL ferr_count got %0d want 1", dut_fe_n - fe0); end
        checks++; if (dut_q.size() - n0 != 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", dut_q.size() - n0); end
        checks++; if (got !== 8'h0F) begin errors++; $display("FAIL ferr_next_byte got %h want 0f", got); end
    endtask

    task automatic test_glitch();
        int n0, fe0, ov0;
        n0 = dut_q.size(); fe0 = dut_fe_n; ov0 = dut_ov_n;
        drive_line(1'b0, 1'b0);
        repeat (3 * BIT_CLKS / 16) @(negedge clk);
        drive_line(1'b0, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (dut_q.size() != n0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", dut_q.size() - n0); end
        checks++; if (dut_fe_n != fe0) begin errors++; $display("FAIL glitch_fe got %0d want 0", dut_fe_n - fe0); end
        checks++; if (dut_ov_n != ov0) begin errors++; $display("FAIL glitch_ov got %0d want 0", dut_ov_n - ov0); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL glitch_level got %0d want 0", fifo_level); end
    endtask

    // big has seen A5 (released at once, opening a 1e6-cycle gap) and then queued
    // 06,01,02,03,04,0F: six held. Two more fill it; the next two are overruns.
    task automatic test_overrun();
        checks++; if (big_level !== 4'd6) begin errors++; $display("FAIL ovr_start_level got %0d want 6", big_level); end
        send_frame(1'b0, 8'h10, 1'b1);
        send_frame(1'b0, 8'h11, 1'b1);
        checks++; if (big_level !== 4'd8) begin errors++; $display("FAIL ovr_full_level got %0d want 8", big_level); end
        checks++; if (big_ov_n != 0) begin errors++; $display("FAIL ovr_early got %0d want 0", big_ov_n); end
        send_frame(1'b0, 8'h12, 1'b1);
        send_frame(1'b0, 8'h13, 1'b1);
        repeat (40) @(negedge clk);
        checks++; if (big_ov_n != 2) begin errors++; $display("FAIL ovr_count got %0d want 2", big_ov_n); end
        checks++; if (big_level !== 4'd8) begin errors++; $display("FAIL ovr_end_level got %0d want 8", big_level); end
        checks++; if (big_q.size() != 1) begin errors++; $display("FAIL ovr_released got %0d want 1", big_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n0, ov0, fe0;
        logic [7:0] got;
        n0 = big_q.size(); ov0 = big_ov_n; fe0 = big_fe_n;
        // Start bit then three data bits, abort inside the fourth
        drive_line(1'b1, 1'b0); repeat (BIT_CLKS) @(negedge clk);
        drive_line(1'b1, 1'b1); repeat (BIT_CLKS) @(negedge clk);
        drive_line(1'b1, 1'b0); repeat (BIT_CLKS) @(negedge clk);
        drive_line(1'b1, 1'b1); repeat (BIT_CLKS) @(negedge clk);
        drive_line(1'b1, 1'b0); repeat (BIT_CLKS / 2) @(negedge clk);
        reset_big = 1'b1;
        drive_line(1'b1, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (big_level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d want 0", big_level); end
        reset_big = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        checks++; if (big_q.size() != n0) begin errors++; $display("FAIL rst_pulses got %0d want 0", big_q.size() - n0); end
        checks++; if (big_ov_n != ov0 || big_fe_n != fe0) begin errors++; $display("FAIL rst_flags got ov %0d fe %0d want 0 0", big_ov_n - ov0, big_fe_n - fe0); end
        send_frame(1'b1, 8'h3C, 1'b1);
        repeat (40) @(negedge clk);
        got = (big_q.size() > n0) ? big_q[n0] : 8'hxx;
        checks++; if (big_q.size() - n0 != 1) begin errors++; $display("FAIL rst_next_pulses got %0d want 1", big_q.size() - n0); end
        checks++; if (got !== 8'h3C) begin errors++; $display("FAIL rst_next_byte got %h want 3c", got); end
        checks++; if (big_level !== 4'd0) begin errors++; $display("FAIL rst_next_level got %0d want 0", big_level); end
    endtask

    // mid (gap 6000) saw every good byte; backlog forces exact gap spacing and FIFO order
    task automatic test_pacing();
        logic [7:0] exp_q [11];
        logic [7:0] got;
        int min_sp, sp01;
        exp_q = '{8'hA5, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 40000 && mid_q.size() < 11; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++; if (mid_q.size() != 11) begin errors++; $display("FAIL pace_count got %0d want 11", mid_q.size()); end
        for (int i = 0; i < 11; i++) begin
            got = (mid_q.size() > i) ? mid_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL pace_order%0d got %h want %h", i, got, exp_q[i]); end
        end
        min_sp = 1 << 30;
        for (int i = 1; i < mid_t.size(); i++) if (mid_t[i] - mid_t[i-1] < min_sp) min_sp = mid_t[i] - mid_t[i-1];
        sp01 = (mid_t.size() > 1) ? mid_t[1] - mid_t[0] : -1;
        checks++; if (min_sp < MID_GAP) begin errors++; $display("FAIL pace_min_gap got %0d want >=%0d", min_sp, MID_GAP); end
        checks++; if (sp01 != MID_GAP) begin errors++; $display("FAIL pace_backlog_gap got %0d want %0d", sp01, MID_GAP); end
        checks++; if (mid_fe_n != 1 || mid_ov_n != 0) begin errors++; $display("FAIL pace_flags got fe %0d ov %0d want 1 0", mid_fe_n, mid_ov_n); end
        checks++; if (mid_level !== 4'd0) begin errors++; $display("FAIL pace_level got %0d want 0", mid_level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_pacing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
